// File: rtl/herloa_err_eval_pkg.sv
// rtl/herloa_err_eval_pkg.sv - shared states, LFSR taps and error-distance helper
// Purpose: common definitions for the HERLOA error-characterisation controller.
// Contents: FSM state encodings, 32-bit LFSR tap mask, abs_diff() helper.
package herloa_err_eval_pkg;

  // Operand width the helper function and tap mask are built for.
  localparam int DATA_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RUN    = 3'd1;
  localparam state_t ST_DRAIN1 = 3'd2;
  localparam state_t ST_DRAIN2 = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // Fibonacci taps 32,22,2,1 -> bit positions 31,21,1,0.
  localparam logic [2*DATA_W-1:0] LFSR_TAPS = 32'h8020_0003;

  // Unsigned distance between two N-bit values.
  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/herloa_err_eval_if.sv
// rtl/herloa_err_eval_if.sv - control, operand and result bundle of the evaluator
// Purpose: groups the start/busy/done control, external operand handshake and
// result outputs. master = requester (drives start/operands), slave = evaluator.
interface herloa_err_eval_if #(
  parameter int N  = 16,
  parameter int SW = 16
);
  logic            start;
  logic            mode;
  logic [SW-1:0]   num_samples;
  logic [2*N-1:0]  seed;
  logic            op_valid;
  logic            op_ready;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic            busy;
  logic            done;
  logic [SW-1:0]   sample_count;
  logic [SW-1:0]   err_count;
  logic [N+SW-1:0] sum_abs_err;
  logic [N-1:0]    max_abs_err;

  modport master (
    output start, mode, num_samples, seed, op_valid, op_a, op_b,
    input  op_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err
  );

  modport slave (
    input  start, mode, num_samples, seed, op_valid, op_a, op_b,
    output op_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err
  );
endinterface

// File: rtl/herloa_err_eval_herloa.sv
// rtl/herloa_err_eval_herloa.sv - HERLOA approximate adder (combinational)
// Purpose: N-bit adder whose lower K bits are OR-approximated with error reduction.
// Ports: i_a, i_b (N) operands; o_sum (N) approximate sum mod 2^N.
module herloa_err_eval_herloa #(
  parameter int N = 16,
  parameter int K = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);
  logic         w_c;
  logic [K-1:0] w_low;
  logic [N-K-1:0] w_high;

  // Only the top lower-part bit pair generates a carry into the exact part.
  assign w_c = i_a[K-1] & i_b[K-1];
  // Top lower bit: XOR, corrected upward when the next pair would have carried.
  assign w_low[K-1] = (i_a[K-1] ^ i_b[K-1]) | (i_a[K-2] & i_b[K-2]);
  // When a carry is forwarded, saturate the remaining low bits to cut the error.
  assign w_low[K-2:0] = (i_a[K-2:0] | i_b[K-2:0]) | {(K-1){w_c}};
  assign w_high = i_a[N-1:K] + i_b[N-1:K] + {{(N-K-1){1'b0}}, w_c};

  assign o_sum = {w_high, w_low};
endmodule

// File: rtl/herloa_err_eval.sv
// rtl/herloa_err_eval.sv - self-timed HERLOA error-characterisation controller
// Purpose: issues LFSR or external operand pairs through a 3-stage pipeline
// (register, HERLOA vs exact ED, accumulate) and reports error statistics.
// Ports: clk, rst_n (async active-low); bus (slave) carries start/mode/
// num_samples/seed, op_valid/op_ready/op_a/op_b, busy/done and the results.
module herloa_err_eval
  import herloa_err_eval_pkg::*;
#(
  parameter int N  = 16,
  parameter int K  = 9,
  parameter int SW = 16
) (
  input logic clk,
  input logic rst_n,
  herloa_err_eval_if.slave bus
);
  state_t          r_state;
  logic            r_mode;
  logic [SW-1:0]   r_num;
  logic [SW-1:0]   r_issued;
  logic [2*N-1:0]  r_lfsr;
  logic            r_v1;
  logic [N-1:0]    r_a1;
  logic [N-1:0]    r_b1;
  logic            r_v2;
  logic [N-1:0]    r_ed2;
  logic [SW-1:0]   r_cnt;
  logic [SW-1:0]   r_err;
  logic [N+SW-1:0] r_sum;
  logic [N-1:0]    r_max;

  logic            w_run;
  logic            w_ready;
  logic            w_issue;
  logic            w_last;
  logic            w_start;
  logic [2*N-1:0]  w_seed;
  logic [2*N-1:0]  w_lfsr_next;
  logic [N-1:0]    w_opa;
  logic [N-1:0]    w_opb;
  logic [N-1:0]    w_approx;
  logic [N-1:0]    w_exact;

  assign w_run   = (r_state == ST_RUN);
  assign w_ready = w_run && r_mode && (r_issued < r_num);
  assign w_issue = w_run && (r_mode ? (bus.op_valid && w_ready) : 1'b1);
  assign w_last  = w_issue && (r_issued == r_num - 1'b1);
  assign w_start = (r_state == ST_IDLE) && bus.start;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign w_seed      = (bus.seed == '0) ? {{(2*N-1){1'b0}}, 1'b1} : bus.seed;
  assign w_lfsr_next = {r_lfsr[2*N-2:0], ^(r_lfsr & LFSR_TAPS)};

  assign w_opa = r_mode ? bus.op_a : r_lfsr[2*N-1:N];
  assign w_opb = r_mode ? bus.op_b : r_lfsr[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mode   <= 1'b0;
      r_num    <= '0;
      r_issued <= '0;
      r_lfsr   <= {{(2*N-1){1'b0}}, 1'b1};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mode   <= bus.mode;
            r_num    <= bus.num_samples;
            r_lfsr   <= w_seed;
            r_issued <= '0;
            r_state  <= (bus.num_samples == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_issued <= r_issued + 1'b1;
            // The LFSR only advances when its word was consumed.
            if (!r_mode) r_lfsr <= w_lfsr_next;
            if (w_last) r_state <= ST_DRAIN1;
          end
        end
        ST_DRAIN1: r_state <= ST_DRAIN2;
        ST_DRAIN2: r_state <= ST_DONE;
        ST_DONE:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: capture the issued pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_a1 <= '0;
      r_b1 <= '0;
    end else begin
      r_v1 <= w_issue;
      if (w_issue) begin
        r_a1 <= w_opa;
        r_b1 <= w_opb;
      end
    end
  end

  // Stage 2: approximate vs exact sum, register the error distance.
  herloa_err_eval_herloa #(.N(N), .K(K)) u_herloa (
    .i_a   (r_a1),
    .i_b   (r_b1),
    .o_sum (w_approx)
  );

  assign w_exact = r_a1 + r_b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_ed2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) r_ed2 <= abs_diff(w_exact, w_approx);
    end
  end

  // Stage 3: accumulators; cleared on an accepted start, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= '0;
      r_sum <= '0;
      r_max <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_err <= '0;
      r_sum <= '0;
      r_max <= '0;
    end else if (r_v2) begin
      r_cnt <= r_cnt + 1'b1;
      r_err <= r_err + {{(SW-1){1'b0}}, |r_ed2};
      r_sum <= r_sum + {{SW{1'b0}}, r_ed2};
      if (r_ed2 > r_max) r_max <= r_ed2;
    end
  end

  assign bus.op_ready     = w_ready;
  assign bus.busy         = w_run || (r_state == ST_DRAIN1) || (r_state == ST_DRAIN2);
  assign bus.done         = (r_state == ST_DONE);
  assign bus.sample_count = r_cnt;
  assign bus.err_count    = r_err;
  assign bus.sum_abs_err  = r_sum;
  assign bus.max_abs_err  = r_max;
endmodule
